// File: rtl/half_adder_pipe.sv
// half_adder_pipe: registered bank of independent half adders with a saturating carry counter
module half_adder_pipe #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_clr_cnt,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_carry,
    output logic [CNT_W-1:0] o_carry_cnt,
    output logic             o_cnt_sat
);
    localparam logic [CNT_W-1:0] cnt_max = {CNT_W{1'b1}};
    logic [7:0]       pop;
    logic [CNT_W-1:0] base;
    logic [CNT_W+7:0] wide;
    logic [CNT_W-1:0] next_cnt;
    // clear-first base plus this beat's carry popcount, clamped at all-ones
    always_comb begin
        pop = '0;
        for (int k = 0; k < WIDTH; k++) pop = pop + {7'd0, i_a[k] & i_b[k]};
        base = i_clr_cnt ? '0 : o_carry_cnt;
        wide = {8'd0, base} + {{CNT_W{1'b0}}, pop};
        next_cnt = !i_valid ? base : (wide > {8'd0, cnt_max}) ? cnt_max : wide[CNT_W-1:0];
    end
    // result registers load on accepted beats; valid and counter update every edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_sum       <= '0;
            o_carry     <= '0;
            o_carry_cnt <= '0;
        end else begin
            o_valid     <= i_valid;
            o_carry_cnt <= next_cnt;
            if (i_valid) begin
                o_sum   <= i_a ^ i_b;
                o_carry <= i_a & i_b;
            end
        end
    end
    assign o_cnt_sat = o_carry_cnt == cnt_max;
endmodule

// File: tb/tb_half_adder_pipe.sv
// tb_half_adder_pipe: table-driven, directed and randomized checks of half_adder_pipe
module tb_half_adder_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        v1, c1, v8, c8;
    logic [0:0]  a1, b1;
    logic [7:0]  a8, b8;
    logic        ov1, ov8, sat1, sat8;
    logic [0:0]  s1, k1;
    logic [7:0]  s8, k8;
    logic [15:0] n1;
    logic [3:0]  n8;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    half_adder_pipe #(.WIDTH(1), .CNT_W(16)) u1 (
        .i_clk(clk), .i_rst(rst), .i_valid(v1), .i_a(a1), .i_b(b1), .i_clr_cnt(c1),
        .o_valid(ov1), .o_sum(s1), .o_carry(k1), .o_carry_cnt(n1), .o_cnt_sat(sat1)
    );
    half_adder_pipe #(.WIDTH(8), .CNT_W(4)) u8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .i_a(a8), .i_b(b8), .i_clr_cnt(c8),
        .o_valid(ov8), .o_sum(s8), .o_carry(k8), .o_carry_cnt(n8), .o_cnt_sat(sat8)
    );

    typedef struct {logic a, b, sum, carry;} vec1_t;
    typedef struct {logic [7:0] a, b, sum, carry; int cnt;} vec8_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid1"}, 64'(ov1), 0);
        chk({tag, " sum1"}, 64'(s1), 0);
        chk({tag, " carry1"}, 64'(k1), 0);
        chk({tag, " cnt1"}, 64'(n1), 0);
        chk({tag, " sat1"}, 64'(sat1), 0);
        chk({tag, " valid8"}, 64'(ov8), 0);
        chk({tag, " sum8"}, 64'(s8), 0);
        chk({tag, " carry8"}, 64'(k8), 0);
        chk({tag, " cnt8"}, 64'(n8), 0);
        chk({tag, " sat8"}, 64'(sat8), 0);
    endtask

    initial begin
        vec1_t t1[4];
        vec8_t t8[4];
        int m_cnt1, m_cnt8;
        logic m_v1, m_v8;
        logic [0:0] m_s1, m_k1;
        logic [7:0] m_s8, m_k8;
        t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        t1[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
        t1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        t1[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        t8[0] = '{8'hF0, 8'hCC, 8'h3C, 8'hC0, 2};
        t8[1] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 10};
        t8[2] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 15};
        t8[3] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 15};
        rst = 1'b1; v1 = 0; c1 = 0; v8 = 0; c8 = 0; a1 = 0; b1 = 0; a8 = 0; b8 = 0;
        #12;
        chk_zero("reset");
        @(negedge clk) rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            v1 = 1; a1 = t1[i].a; b1 = t1[i].b;
            step();
            chk($sformatf("ex1 valid %0d", i), 64'(ov1), 1);
            chk($sformatf("ex1 sum %0d", i), 64'(s1), 64'(t1[i].sum));
            chk($sformatf("ex1 carry %0d", i), 64'(k1), 64'(t1[i].carry));
        end
        chk("ex1 cnt", 64'(n1), 1);
        a1 = 1; b1 = 1;
        step();
        v1 = 0; a1 = 0; b1 = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold valid %0d", i), 64'(ov1), 0);
            chk($sformatf("hold sum %0d", i), 64'(s1), 0);
            chk($sformatf("hold carry %0d", i), 64'(k1), 1);
            chk($sformatf("hold cnt %0d", i), 64'(n1), 2);
        end
        v8 = 1;
        for (int i = 0; i < 4; i++) begin
            a8 = t8[i].a; b8 = t8[i].b;
            step();
            chk($sformatf("ml valid %0d", i), 64'(ov8), 1);
            chk($sformatf("ml sum %0d", i), 64'(s8), 64'(t8[i].sum));
            chk($sformatf("ml carry %0d", i), 64'(k8), 64'(t8[i].carry));
            chk($sformatf("ml cnt %0d", i), 64'(n8), 64'(t8[i].cnt));
            chk($sformatf("ml sat %0d", i), 64'(sat8), 64'(t8[i].cnt == 15));
        end
        c8 = 1; a8 = 8'h1F; b8 = 8'h1F;
        step();
        chk("clr beat to 5", 64'(n8), 5);
        a8 = 8'h03; b8 = 8'h01;
        step();
        chk("clr collision cnt", 64'(n8), 1);
        chk("clr collision sum", 64'(s8), 8'h02);
        chk("clr collision carry", 64'(k8), 8'h01);
        v8 = 0;
        step();
        chk("clr idle cnt", 64'(n8), 0);
        chk("clr idle sum hold", 64'(s8), 8'h02);
        chk("clr idle valid", 64'(ov8), 0);
        c8 = 0; v8 = 1; a8 = 8'hFF; b8 = 8'h0F; v1 = 1; a1 = 1; b1 = 1;
        step();
        #2 rst = 1'b1;
        #1;
        chk_zero("async reset");
        @(negedge clk) rst = 1'b0;
        v1 = 0; v8 = 0;
        step();
        chk("post reset valid1", 64'(ov1), 0);
        chk("post reset valid8", 64'(ov8), 0);
        m_cnt1 = 0; m_cnt8 = 0; m_v1 = 0; m_v8 = 0; m_s1 = 0; m_k1 = 0; m_s8 = 0; m_k8 = 0;
        for (int i = 0; i < 400; i++) begin
            v1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); c1 = ($urandom_range(0, 15) == 0);
            v8 = ($urandom_range(0, 3) != 0); a8 = 8'($urandom); b8 = 8'($urandom); c8 = ($urandom_range(0, 7) == 0);
            if (c1) m_cnt1 = 0;
            if (c8) m_cnt8 = 0;
            m_v1 = v1;
            m_v8 = v8;
            if (v1) begin
                m_s1 = a1 ^ b1; m_k1 = a1 & b1;
                m_cnt1 = (m_cnt1 + $countones(a1 & b1) > 65535) ? 65535 : m_cnt1 + $countones(a1 & b1);
            end
            if (v8) begin
                m_s8 = a8 ^ b8; m_k8 = a8 & b8;
                m_cnt8 = (m_cnt8 + $countones(a8 & b8) > 15) ? 15 : m_cnt8 + $countones(a8 & b8);
            end
            step();
            chk($sformatf("rnd valid1 %0d", i), 64'(ov1), 64'(m_v1));
            chk($sformatf("rnd sum1 %0d", i), 64'(s1), 64'(m_s1));
            chk($sformatf("rnd carry1 %0d", i), 64'(k1), 64'(m_k1));
            chk($sformatf("rnd cnt1 %0d", i), 64'(n1), 64'(m_cnt1));
            chk($sformatf("rnd valid8 %0d", i), 64'(ov8), 64'(m_v8));
            chk($sformatf("rnd sum8 %0d", i), 64'(s8), 64'(m_s8));
            chk($sformatf("rnd carry8 %0d", i), 64'(k8), 64'(m_k8));
            chk($sformatf("rnd cnt8 %0d", i), 64'(n8), 64'(m_cnt8));
            chk($sformatf("rnd sat8 %0d", i), 64'(sat8), 64'(m_cnt8 == 15));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
